// File: rtl/duty_step_pkg.sv
// Shared types and helpers for the duty-step button debouncer.
//   db_state_t : per-button debounce FSM states
//   cnt_width  : counter width large enough for the longest cycle window
package duty_step_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Width of a counter that must reach (max(a,b,c) - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/duty_step_debouncer_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and (optionally)
// auto-repeat. Emits a registered 1-cycle raw pulse per accepted press.
// Optional feature macro: DUTY_STEP_AUTO_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk         in  system clock
//   rst         in  synchronous reset, active-high
//   btn_i       in  raw asynchronous button, active-high
//   raw_pulse_o out 1-cycle step request (before arbitration)
//   level_o     out debounced level (high in PRESSED / RELEASE_WAIT)
module debounce_channel
  import duty_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic raw_pulse_o,
  output logic level_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  db_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

`ifdef DUTY_STEP_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_DELAY_LAST  = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] REP_PERIOD_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);
  logic [CW-1:0]   rcnt_q, rcnt_d;
  // 0: waiting out the initial hold delay, 1: periodic repeat phase
  logic            rphase_q, rphase_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
`endif
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
`endif
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          // Only this transition produces a press pulse.
          state_d = PRESSED;
          pulse_d = 1'b1;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          rcnt_d   = '0;
          rphase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          rcnt_d   = '0;
          rphase_d = 1'b0;
`endif
        end else begin
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          if (!rphase_q) begin
            if (rcnt_q == REP_DELAY_LAST) begin
              pulse_d  = 1'b1;
              rcnt_d   = '0;
              rphase_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end else if (rcnt_q == REP_PERIOD_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          // Release bounce: go back without a new pulse; repeat delay restarts.
          state_d = PRESSED;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          rcnt_d   = '0;
          rphase_d = 1'b0;
`endif
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign raw_pulse_o = pulse_q;
  assign level_o     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/duty_step_debouncer.sv
// Duty-step button conditioner feeding the PWM generator's increase/decrease
// inputs. Two debounce channels plus an arbiter with registered outputs.
// Optional feature macro: DUTY_STEP_AUTO_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk          in  system clock
//   rst          in  synchronous reset, active-high
//   inc_btn_i    in  raw increase button (async, active-high)
//   dec_btn_i    in  raw decrease button (async, active-high)
//   inc_pulse_o  out registered 1-cycle increase request
//   dec_pulse_o  out registered 1-cycle decrease request
//   inc_level_o  out debounced increase level
//   dec_level_o  out debounced decrease level
module duty_step_debouncer
  import duty_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_btn_i,
  input  logic dec_btn_i,
  output logic inc_pulse_o,
  output logic dec_pulse_o,
  output logic inc_level_o,
  output logic dec_level_o
);

  logic inc_raw, dec_raw;
  logic inc_lvl, dec_lvl;
  logic inc_pulse_q, inc_pulse_d;
  logic dec_pulse_q, dec_pulse_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
  ) u_inc (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (inc_btn_i),
    .raw_pulse_o (inc_raw),
    .level_o     (inc_lvl)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (dec_btn_i),
    .raw_pulse_o (dec_raw),
    .level_o     (dec_lvl)
  );

  // Simultaneous pulses cancel; a held opposite button locks this one out.
  always_comb begin
    inc_pulse_d = inc_raw & ~dec_raw & ~dec_lvl;
    dec_pulse_d = dec_raw & ~inc_raw & ~inc_lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
    end
  end

  assign inc_pulse_o = inc_pulse_q;
  assign dec_pulse_o = dec_pulse_q;
  assign inc_level_o = inc_lvl;
  assign dec_level_o = dec_lvl;

endmodule

// File: tb/tb_duty_step_debouncer.sv
module tb_duty_step_debouncer;

  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 10;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
  localparam int HOLD40_CNT = 3;
`else
  localparam int HOLD40_CNT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic inc_btn_i, dec_btn_i;
  logic inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o;

  duty_step_debouncer #(
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inc_btn_i   (inc_btn_i),
    .dec_btn_i   (dec_btn_i),
    .inc_pulse_o (inc_pulse_o),
    .dec_pulse_o (dec_pulse_o),
    .inc_level_o (inc_level_o),
    .dec_level_o (dec_level_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int inc_hits[$];
  int dec_hits[$];
  int ilvl_first;
  int ilvl_cnt;

  typedef struct {
    int is, il;       // inc pin high for cycles [is, is+il)
    int ds, dl;       // dec pin high for cycles [ds, ds+dl)
    int rc;           // cycle with rst asserted (-1: none)
    int n;            // cycles observed
    int e_icnt, e_ifirst, e_dcnt, e_dfirst, e_ilvl;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_rec();
    inc_hits.delete();
    dec_hits.delete();
    ilvl_first = -1;
    ilvl_cnt   = 0;
  endtask

  task automatic sample(input int k);
    if (inc_pulse_o) inc_hits.push_back(k);
    if (dec_pulse_o) dec_hits.push_back(k);
    if (inc_level_o) begin
      ilvl_cnt++;
      if (ilvl_first < 0) ilvl_first = k;
    end
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic do_reset();
    inc_btn_i = 1'b0;
    dec_btn_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    clear_rec();
    for (int k = 0; k < v.n; k++) begin
      inc_btn_i = (k >= v.is) && (k < v.is + v.il);
      dec_btn_i = (k >= v.ds) && (k < v.ds + v.dl);
      rst       = (k == v.rc);
      sample(k);
      step();
    end
    inc_btn_i = 1'b0;
    dec_btn_i = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    //            is il ds dl  rc   n  icnt        ifst dcnt dfst ilvl
    vecs[0] = '{0, 40, 0, 0,  -1, 45, HOLD40_CNT, 12,  0,  -1,  11};  // held press
    vecs[1] = '{0, 5,  0, 0,  -1, 20, 0,          -1,  0,  -1,  -1};  // short glitch
    vecs[2] = '{0, 8,  0, 0,  -1, 25, 0,          -1,  0,  -1,  -1};  // one cycle short
    vecs[3] = '{0, 9,  0, 0,  -1, 25, 1,          12,  0,  -1,  11};  // just long enough
    vecs[4] = '{0, 30, 0, 30, -1, 35, 0,          -1,  0,  -1,  11};  // simultaneous
    vecs[5] = '{0, 0,  0, 20, -1, 25, 0,          -1,  1,  12,  -1};  // dec only
    vecs[6] = '{5, 20, 0, 0,  -1, 30, 1,          17,  0,  -1,  16};  // late press
    vecs[7] = '{0, 30, 0, 0,   6, 30, 1,          19,  0,  -1,  18};  // reset mid-count
    vecs[8] = '{0, 30, 15, 20, -1, 40, 1,         12,  0,  -1,  11};  // dec locked out
    vecs[9] = '{0, 40, 0, 0,  11, 40, 1,          24,  0,  -1,  11};  // reset on pulse

    inc_btn_i = 1'b0;
    dec_btn_i = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_inc_pulse", int'(inc_pulse_o), 0);
    chk("rst_dec_pulse", int'(dec_pulse_o), 0);
    chk("rst_inc_level", int'(inc_level_o), 0);
    chk("rst_dec_level", int'(dec_level_o), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_vec(vecs[i]);
      chk($sformatf("v%0d_inc_cnt", i),   inc_hits.size(),    vecs[i].e_icnt);
      chk($sformatf("v%0d_inc_first", i), first_of(inc_hits), vecs[i].e_ifirst);
      chk($sformatf("v%0d_dec_cnt", i),   dec_hits.size(),    vecs[i].e_dcnt);
      chk($sformatf("v%0d_dec_first", i), first_of(dec_hits), vecs[i].e_dfirst);
      chk($sformatf("v%0d_inc_lvl", i),   ilvl_first,         vecs[i].e_ilvl);
    end

    // Release bounce: toggles every 3 cycles after a valid press.
    do_reset();
    clear_rec();
    for (int k = 0; k < 60; k++) begin
      if (k < 20)      inc_btn_i = 1'b1;
      else if (k < 32) inc_btn_i = (((k - 20) / 3) % 2) == 1;
      else             inc_btn_i = 1'b0;
      sample(k);
      step();
    end
    chk("bounce_cnt",     inc_hits.size(),    1);
    chk("bounce_first",   first_of(inc_hits), 12);
    chk("bounce_lvl_len", ilvl_cnt,           32);
    chk("bounce_lvl_end", int'(inc_level_o),  0);

    // Lockout: dec held, inc pressed meanwhile, then a fresh inc press.
    do_reset();
    clear_rec();
    for (int k = 0; k < 90; k++) begin
      dec_btn_i = (k < 30);
      inc_btn_i = ((k >= 15) && (k < 40)) || ((k >= 60) && (k < 80));
      sample(k);
      if (k == 45) chk("lock_dec_lvl_low", int'(dec_level_o), 0);
      step();
    end
    chk("lock_inc_cnt",   inc_hits.size(),    1);
    chk("lock_inc_first", first_of(inc_hits), 72);
    chk("lock_dec_cnt",   dec_hits.size(),    1);
    chk("lock_dec_first", first_of(dec_hits), 12);

`ifdef DUTY_STEP_AUTO_REPEAT_EN
    // Auto-repeat: held for 60 cycles.
    do_reset();
    clear_rec();
    for (int k = 0; k < 60; k++) begin
      inc_btn_i = 1'b1;
      sample(k);
      step();
    end
    inc_btn_i = 1'b0;
    chk("rep_cnt", inc_hits.size(), 4);
    if (inc_hits.size() == 4) begin
      chk("rep_p0", inc_hits[0], 12);
      chk("rep_p1", inc_hits[1], 32);
      chk("rep_p2", inc_hits[2], 42);
      chk("rep_p3", inc_hits[3], 52);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
